alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 4..32).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), iteration-counter width; derived, not overridden.
REQ-003 Reset is synchronous and active-high; there is one clock.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request; sampled only while busy=0.
REQ-007 alu_sel  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 cmp.
REQ-008 a  in  WIDTH  operand A, unsigned; captured on accepted start.
REQ-009 b  in  WIDTH  operand B, full width, unsigned; captured on accepted start.
REQ-010 busy  out  1  high while an iterative op executes.
REQ-011 done  out  1  one-cycle pulse; result and flag outputs valid from that cycle.
REQ-012 alu_out  out  WIDTH  result low word: sum, difference, logic result, product low, quotient, or cmp.
REQ-013 alu_hi  out  WIDTH  product high word (mul), remainder (div), else 0.
REQ-014 carry_out  out  1  add carry, sub borrow, mul high word nonzero, div by zero; else 0.
REQ-015 zero, negative, overflow, div_zero  out  1 each  status flags (REQ-022).

Function
REQ-016 Start is accepted in the cycle start=1 and busy=0; a, b and alu_sel are captured then. Start while busy=1 is ignored, with no effect on state.
REQ-017 FSM states: IDLE, ITER, DONE.
- IDLE/DONE + accepted fast op (add, sub, and, or, xor, cmp, or div with b=0) -> DONE.
- IDLE/DONE + accepted mul/div with b!=0 -> ITER.
- ITER -> DONE after WIDTH iterations.
- DONE without accepted start -> IDLE.
REQ-018 Latency: fast ops assert done exactly 1 cycle after the accepting edge. Mul/div (b!=0) assert done exactly WIDTH+1 cycles after it. busy=1 for the WIDTH ITER cycles only.
REQ-019 Mul is shift-add, one partial product per ITER cycle; {alu_hi, alu_out} = a*b (2*WIDTH bits, exact).
REQ-020 Div is restoring, one quotient bit per ITER cycle: alu_out = a/b, alu_hi = a%b.
REQ-021 Div with b=0:
- alu_out=0, alu_hi=a.
- carry_out=1, div_zero=1.
- No ITER; fast-op latency.
REQ-022 Flag rules:
- zero = (alu_out==0 and alu_hi==0).
- negative = alu_out[WIDTH-1].
- overflow = two's-complement signed overflow for add/sub, else 0.
- cmp: alu_out = 1 if a==b else 0; carry_out = (a<b).
REQ-023 Add/sub wrap modulo 2^WIDTH; carry/borrow is bit WIDTH of the unsigned result.
REQ-024 Outputs are registered, update only in the DONE-entry cycle, and hold until the next done.
REQ-025 Back-to-back: a start accepted in the DONE cycle begins a new op with no bubble.

Reset
REQ-026 rst=1 at a clock edge forces state IDLE, counter 0, busy=0, done=0, and all outputs/flags to 0. rst overrides start.
REQ-027 rst during ITER aborts the op; no done is produced for it.

Structure
REQ-028 Package alu_pkg holds the opcode localparams (OP_ADD..OP_CMP) and the state encoding (IDLE, ITER, DONE).
REQ-029 One sub-module, alu_muldiv_iter, holds the shared shift register, partial-remainder/accumulator and iteration counter. The top module holds the FSM, fast ops and flags.

Verification (WIDTH=8)
REQ-030 add a=200,b=100 -> next cycle done=1, alu_out=44, carry_out=1, overflow=0.
REQ-031 sub a=5,b=7 -> next cycle alu_out=254, carry_out=1, negative=1.
REQ-032 mul a=200,b=200 -> busy for 8 cycles, done at start+9, alu_hi=0x9C, alu_out=0x40, carry_out=1. A start issued at cycle 3 is ignored.
REQ-033 div a=100,b=7 -> done at start+9, alu_out=14, alu_hi=2. Then div a=9,b=0 -> done at start+1, alu_out=0, alu_hi=9, div_zero=1, carry_out=1.
REQ-034 mul started, rst=1 at cycle 4 -> from next edge busy=0, all outputs 0, and no done follows.
REQ-035 cmp a=b=0x3C issued in the DONE cycle of a prior add -> done the next cycle with alu_out=1, carry_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide,
// one bit per step. Exposes next-step values so the caller can register
// the final result on the same edge as the last iteration.
module alu_muldiv_iter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic             o_last
);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_opnd;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;

  // One multiply or divide step computed from the current registers
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opnd});
    o_lo_nxt = '0;
    o_hi_nxt = '0;
    if (r_div) begin
      o_hi_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];
      o_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi_nxt = w_sum[WIDTH:1];
      o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
    o_last = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Operand load, per-step register update and iteration count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_lo   <= i_a;
      r_hi   <= '0;
      r_opnd <= i_b;
      r_div  <= i_is_div;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_lo   <= o_lo_nxt;
      r_hi   <= o_hi_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, WIDTH-cycle mul/div,
// registered result and flags that hold until the next completion.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic             w_accept;
  logic             w_iter_op;
  logic             w_load_res;
  logic             w_last;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_res_c;
  logic             w_res_ov;
  logic             w_res_dz;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_hi;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_ov;
  logic             r_dz;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept && w_iter_op),
    .i_is_div (alu_sel == OP_DIV),
    .i_a      (a),
    .i_b      (b),
    .i_step   (r_state == ITER),
    .o_lo_nxt (w_iter_lo),
    .o_hi_nxt (w_iter_hi),
    .o_last   (w_last)
  );

  // Next-state decode and result-load strobe
  always_comb begin
    w_accept    = start && (r_state != ITER);
    w_iter_op   = (alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && (b != '0));
    w_state_nxt = IDLE;
    w_load_res  = 1'b0;
    case (r_state)
      ITER: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_load_res  = 1'b1;
        end else begin
          w_state_nxt = ITER;
        end
      end
      default: begin
        if (w_accept) begin
          w_state_nxt = w_iter_op ? ITER : DONE;
          w_load_res  = !w_iter_op;
        end
      end
    endcase
  end

  // Result selection: iterative result on the last step, else fast ops
  always_comb begin
    w_sum    = {1'b0, a} + {1'b0, b};
    w_diff   = {1'b0, a} - {1'b0, b};
    w_res_lo = '0;
    w_res_hi = '0;
    w_res_c  = 1'b0;
    w_res_ov = 1'b0;
    w_res_dz = 1'b0;
    if (r_state == ITER) begin
      w_res_lo = w_iter_lo;
      w_res_hi = w_iter_hi;
      w_res_c  = (r_op == OP_MUL) && (w_iter_hi != '0);
    end else begin
      case (alu_sel)
        OP_ADD: begin
          w_res_lo = w_sum[WIDTH-1:0];
          w_res_c  = w_sum[WIDTH];
          w_res_ov = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          w_res_lo = w_diff[WIDTH-1:0];
          w_res_c  = w_diff[WIDTH];
          w_res_ov = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND: w_res_lo = a & b;
        OP_OR:  w_res_lo = a | b;
        OP_XOR: w_res_lo = a ^ b;
        OP_DIV: begin
          w_res_hi = a;
          w_res_c  = 1'b1;
          w_res_dz = 1'b1;
        end
        OP_CMP: begin
          w_res_lo = {{(WIDTH-1){1'b0}}, (a == b)};
          w_res_c  = (a < b);
        end
        default: ;
      endcase
    end
  end

  // State register, opcode capture and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_ADD;
      r_out   <= '0;
      r_hi    <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_ov    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_op <= alu_sel;
      if (w_load_res) begin
        r_out <= w_res_lo;
        r_hi  <= w_res_hi;
        r_c   <= w_res_c;
        r_z   <= (w_res_lo == '0) && (w_res_hi == '0);
        r_n   <= w_res_lo[WIDTH-1];
        r_ov  <= w_res_ov;
        r_dz  <= w_res_dz;
      end
    end
  end

  assign busy      = (r_state == ITER);
  assign done      = (r_state == DONE);
  assign alu_out   = r_out;
  assign alu_hi    = r_hi;
  assign carry_out = r_c;
  assign zero      = r_z;
  assign negative  = r_n;
  assign overflow  = r_ov;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_sel;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] alu_out, alu_hi;
  logic         carry_out, zero, negative, overflow, div_zero;

  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_sel   (alu_sel),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .alu_out   (alu_out),
    .alu_hi    (alu_hi),
    .carry_out (carry_out),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic [2:0] sel;
    logic [7:0] va, vb;
    logic [7:0] e_out, e_hi;
    logic     e_c, e_z, e_n, e_ov, e_dz;
    int       e_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [7:0] eo, input logic [7:0] eh,
                          input logic ec, input logic ez, input logic en,
                          input logic eov, input logic edz);
    chk({nm, ".alu_out"},   alu_out,   eo);
    chk({nm, ".alu_hi"},    alu_hi,    eh);
    chk({nm, ".carry_out"}, carry_out, ec);
    chk({nm, ".zero"},      zero,      ez);
    chk({nm, ".negative"},  negative,  en);
    chk({nm, ".overflow"},  overflow,  eov);
    chk({nm, ".div_zero"},  div_zero,  edz);
  endtask

  // Issue one op and measure latency (cycles after accept until done) and busy cycles.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] va, input logic [7:0] vb,
                        output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; alu_sel = sel; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, nbusy, seen;

    vecs[0]  = '{"add_200_100", 3'b000, 8'd200, 8'd100, 8'd44,  8'd0,   1, 0, 0, 0, 0, 1};
    vecs[1]  = '{"sub_5_7",     3'b001, 8'd5,   8'd7,   8'd254, 8'd0,   1, 0, 1, 0, 0, 1};
    vecs[2]  = '{"and_zero",    3'b010, 8'hF0,  8'h0F,  8'h00,  8'h00,  0, 1, 0, 0, 0, 1};
    vecs[3]  = '{"or",          3'b011, 8'hA0,  8'h05,  8'hA5,  8'h00,  0, 0, 1, 0, 0, 1};
    vecs[4]  = '{"xor",         3'b100, 8'hFF,  8'h0F,  8'hF0,  8'h00,  0, 0, 1, 0, 0, 1};
    vecs[5]  = '{"add_ovf",     3'b000, 8'd100, 8'd50,  8'h96,  8'h00,  0, 0, 1, 1, 0, 1};
    vecs[6]  = '{"sub_ovf",     3'b001, 8'h80,  8'h01,  8'h7F,  8'h00,  0, 0, 0, 1, 0, 1};
    vecs[7]  = '{"mul_200_200", 3'b101, 8'd200, 8'd200, 8'h40,  8'h9C,  1, 0, 0, 0, 0, 9};
    vecs[8]  = '{"div_100_7",   3'b110, 8'd100, 8'd7,   8'd14,  8'd2,   0, 0, 0, 0, 0, 9};
    vecs[9]  = '{"div_by_0",    3'b110, 8'd9,   8'd0,   8'd0,   8'd9,   1, 0, 0, 0, 1, 1};
    vecs[10] = '{"cmp_eq",      3'b111, 8'h3C,  8'h3C,  8'd1,   8'd0,   0, 0, 0, 0, 0, 1};
    vecs[11] = '{"cmp_lt",      3'b111, 8'd3,   8'd5,   8'd0,   8'd0,   1, 1, 0, 0, 0, 1};
    vecs[12] = '{"mul_15_17",   3'b101, 8'd15,  8'd17,  8'hFF,  8'h00,  0, 0, 1, 0, 0, 9};
    vecs[13] = '{"div_255_16",  3'b110, 8'd255, 8'd16,  8'd15,  8'd15,  0, 0, 0, 0, 0, 9};
    vecs[14] = '{"add_wrap",    3'b000, 8'hFF,  8'h01,  8'h00,  8'h00,  1, 1, 0, 0, 0, 1};

    rst = 1'b1; start = 1'b0; alu_sel = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].sel, vecs[i].va, vecs[i].vb, lat, nbusy);
      chk({vecs[i].name, ".done"}, done, 1);
      chk({vecs[i].name, ".latency"}, lat, vecs[i].e_lat);
      chk({vecs[i].name, ".busy_cycles"}, nbusy, vecs[i].e_lat - 1);
      chk_outs(vecs[i].name, vecs[i].e_out, vecs[i].e_hi, vecs[i].e_c, vecs[i].e_z,
               vecs[i].e_n, vecs[i].e_ov, vecs[i].e_dz);
      @(negedge clk);
      chk({vecs[i].name, ".done_pulse"}, done, 0);
      chk({vecs[i].name, ".hold_out"}, alu_out, vecs[i].e_out);
    end

    // Start while busy must be ignored
    @(negedge clk);
    start = 1'b1; alu_sel = 3'b101; a = 8'd200; b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (lat == 3) begin start = 1'b1; alu_sel = 3'b000; a = 8'd1; b = 8'd1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ign.done", done, 1);
    chk("ign.latency", lat, 9);
    chk_outs("ign", 8'h40, 8'h9C, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ign.no_extra_done", done, 0);

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    start = 1'b1; alu_sel = 3'b101; a = 8'd200; b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk_outs("abort", 0, 0, 0, 0, 0, 0, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort.no_done", seen, 0);

    // Back-to-back: cmp issued during the DONE cycle of an add
    run_op(3'b000, 8'd200, 8'd100, lat, nbusy);
    chk("b2b.add_done", done, 1);
    chk("b2b.add_out", alu_out, 8'd44);
    start = 1'b1; alu_sel = 3'b111; a = 8'h3C; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.cmp_done", done, 1);
    chk("b2b.cmp_out", alu_out, 8'd1);
    chk("b2b.cmp_carry", carry_out, 0);
    @(negedge clk);
    chk("b2b.idle", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
